// File: rtl/fp_pkg.sv
// Shared FP constants and the per-operand class record used by the FP front end.
package fp_pkg;

  localparam int FLAG_SNAN   = 5;
  localparam int FLAG_QNAN   = 4;
  localparam int FLAG_INF    = 3;
  localparam int FLAG_ZERO   = 2;
  localparam int FLAG_SUB    = 1;
  localparam int FLAG_NORMAL = 0;

  localparam int FC_NEG_INF  = 0;
  localparam int FC_NEG_NORM = 1;
  localparam int FC_NEG_SUB  = 2;
  localparam int FC_NEG_ZERO = 3;
  localparam int FC_POS_ZERO = 4;
  localparam int FC_POS_SUB  = 5;
  localparam int FC_POS_NORM = 6;
  localparam int FC_POS_INF  = 7;
  localparam int FC_SNAN     = 8;
  localparam int FC_QNAN     = 9;

  localparam logic [9:0] FC_SNAN_MASK = 10'b01_0000_0000;
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  typedef struct packed {
    logic [5:0] flags;
    logic [9:0] fclass;
  } fp_op_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single operand classifier: one-hot class flags and FCLASS mask.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output logic [5:0]           flags_o,
  output logic [9:0]           fclass_o
);

  logic             sgn;
  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;
  logic             e_max, e_min, m_zero;

  always_comb begin
    sgn    = op_i[EXP_W+MAN_W];
    e      = op_i[EXP_W+MAN_W-1:MAN_W];
    m      = op_i[MAN_W-1:0];
    e_max  = (e == EXP_ALL_ONES[EXP_W-1:0]);
    e_min  = (e == '0);
    m_zero = (m == '0);

    flags_o              = '0;
    flags_o[FLAG_SNAN]   = e_max & !m_zero & !m[MAN_W-1];
    flags_o[FLAG_QNAN]   = e_max & m[MAN_W-1];
    flags_o[FLAG_INF]    = e_max & m_zero;
    flags_o[FLAG_ZERO]   = e_min & m_zero;
    flags_o[FLAG_SUB]    = e_min & !m_zero;
    flags_o[FLAG_NORMAL] = !e_max & !e_min;

    // NaN classes ignore the sign; all others split by sign.
    fclass_o              = '0;
    fclass_o[FC_NEG_INF]  = sgn  & flags_o[FLAG_INF];
    fclass_o[FC_NEG_NORM] = sgn  & flags_o[FLAG_NORMAL];
    fclass_o[FC_NEG_SUB]  = sgn  & flags_o[FLAG_SUB];
    fclass_o[FC_NEG_ZERO] = sgn  & flags_o[FLAG_ZERO];
    fclass_o[FC_POS_ZERO] = !sgn & flags_o[FLAG_ZERO];
    fclass_o[FC_POS_SUB]  = !sgn & flags_o[FLAG_SUB];
    fclass_o[FC_POS_NORM] = !sgn & flags_o[FLAG_NORMAL];
    fclass_o[FC_POS_INF]  = !sgn & flags_o[FLAG_INF];
    fclass_o[FC_SNAN]     = flags_o[FLAG_SNAN];
    fclass_o[FC_QNAN]     = flags_o[FLAG_QNAN];
  end

endmodule

// File: rtl/fp_operand_classify.sv
// Operand front end: classifies an rs1/rs2 pair and registers it behind a 2-entry skid buffer.
module fp_operand_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_a,
  output logic [EXP_W+MAN_W:0] out_b,
  output logic [5:0]           out_a_flags,
  output logic [5:0]           out_b_flags,
  output logic [9:0]           out_a_fclass,
  output logic                 out_nv
);

  localparam int W = 1 + EXP_W + MAN_W;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    fp_op_class_t a_cls;
    logic [5:0]   b_flags;
    logic         nv;
  } pair_t;

  logic [5:0] a_flags, b_flags;
  logic [9:0] a_fclass, b_fclass;
  pair_t      new_pair;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op_i(in_a), .flags_o(a_flags), .fclass_o(a_fclass)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op_i(in_b), .flags_o(b_flags), .fclass_o(b_fclass)
  );

  always_comb begin
    new_pair.a            = in_a;
    new_pair.b            = in_b;
    new_pair.a_cls.flags  = a_flags;
    new_pair.a_cls.fclass = a_fclass;
    new_pair.b_flags      = b_flags;
    new_pair.nv           = a_flags[FLAG_SNAN] | (b_fclass == FC_SNAN_MASK);
  end

  logic  main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
  pair_t main_q, main_d, skid_q, skid_d;
  logic  accept, drain;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    accept   = in_valid & in_ready_q;
    drain    = main_v_q & out_ready;

    // Main is free this cycle: refill from skid first to keep acceptance order.
    if (!main_v_q || drain) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d   = new_pair;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = new_pair;
      skid_v_d = 1'b1;
    end

    in_ready_d = !skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = main_v_q;
  assign out_a        = main_q.a;
  assign out_b        = main_q.b;
  assign out_a_flags  = main_q.a_cls.flags;
  assign out_b_flags  = main_q.b_flags;
  assign out_a_fclass = main_q.a_cls.fclass;
  assign out_nv       = main_q.nv;

endmodule
